// File: rtl/mac_rx.sv
// Tag-side MAC receiver: decodes registration headers in the beacon phase and
// data bursts in the scheme phase from a symbol-strobed serial line.
module mac_rx #(
    parameter logic [15:0] MAX_COUNT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sym_en,
    input  logic        sending,
    input  logic        head,
    input  logic        datacmd,
    input  logic [1:0]  ctg,
    output logic        reg_valid,
    output logic [2:0]  reg_id,
    output logic [15:0] reg_size,
    output logic        data_valid,
    output logic [2:0]  data_id,
    output logic [15:0] data_count,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, REG_ID, REG_SIZE, DAT_ID, DATA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  id_sh_q, id_sh_d;
    logic [15:0] size_sh_q, size_sh_d;
    logic [15:0] burst_q, burst_d;
    logic        reg_valid_q, reg_valid_d;
    logic [2:0]  reg_id_q, reg_id_d;
    logic [15:0] reg_size_q, reg_size_d;
    logic        data_valid_q, data_valid_d;
    logic [2:0]  data_id_q, data_id_d;
    logic [15:0] data_count_q, data_count_d;
    logic        err_q, err_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        id_sh_d      = id_sh_q;
        size_sh_d    = size_sh_q;
        burst_d      = burst_q;
        reg_id_d     = reg_id_q;
        reg_size_d   = reg_size_q;
        data_id_d    = data_id_q;
        data_count_d = data_count_q;
        reg_valid_d  = 1'b0;
        data_valid_d = 1'b0;
        err_d        = 1'b0;
        if (sym_en) begin
            case (state_q)
                IDLE: begin
                    if (sending) begin
                        if (!datacmd && !head && ctg == 2'b01) begin
                            state_d   = REG_ID;
                            bit_cnt_d = 4'd0;
                            id_sh_d   = 3'd0;
                        end else if (!datacmd && head && ctg == 2'b10) begin
                            state_d   = DAT_ID;
                            bit_cnt_d = 4'd0;
                            id_sh_d   = 3'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                REG_ID, DAT_ID: begin
                    if (!sending || datacmd) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        id_sh_d = {id_sh_q[1:0], head};
                        if (bit_cnt_q == 4'd2) begin
                            bit_cnt_d = 4'd0;
                            burst_d   = 16'd0;
                            state_d   = (state_q == REG_ID) ? REG_SIZE : DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                REG_SIZE: begin
                    if (!sending || datacmd) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        size_sh_d = {size_sh_q[14:0], head};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            reg_id_d    = id_sh_q;
                            reg_size_d  = {size_sh_q[14:0], head};
                            reg_valid_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (!sending) begin
                        data_id_d    = id_sh_q;
                        data_count_d = burst_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else if (datacmd) begin
                        if (burst_q != MAX_COUNT) burst_d = burst_q + 16'd1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            id_sh_q      <= 3'd0;
            size_sh_q    <= 16'd0;
            burst_q      <= 16'd0;
            reg_valid_q  <= 1'b0;
            reg_id_q     <= 3'd0;
            reg_size_q   <= 16'd0;
            data_valid_q <= 1'b0;
            data_id_q    <= 3'd0;
            data_count_q <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            id_sh_q      <= id_sh_d;
            size_sh_q    <= size_sh_d;
            burst_q      <= burst_d;
            reg_valid_q  <= reg_valid_d;
            reg_id_q     <= reg_id_d;
            reg_size_q   <= reg_size_d;
            data_valid_q <= data_valid_d;
            data_id_q    <= data_id_d;
            data_count_q <= data_count_d;
            err_q        <= err_d;
        end
    end

    assign reg_valid  = reg_valid_q;
    assign reg_id     = reg_id_q;
    assign reg_size   = reg_size_q;
    assign data_valid = data_valid_q;
    assign data_id    = data_id_q;
    assign data_count = data_count_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: beacon/scheme frames, truncation, resets,
// sym_en gaps, saturation and idle-line errors.
module tb_mac_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sym_en = 1'b0;
    logic        sending = 1'b0;
    logic        head = 1'b0;
    logic        datacmd = 1'b0;
    logic [1:0]  ctg = 2'b00;
    logic        reg_valid;
    logic [2:0]  reg_id;
    logic [15:0] reg_size;
    logic        data_valid;
    logic [2:0]  data_id;
    logic [15:0] data_count;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_rv = 0, n_dv = 0, n_err = 0;
    int s_rv, s_dv, s_err;

    mac_rx #(.MAX_COUNT(16'd20)) dut (
        .clk(clk), .rst_n(rst_n), .sym_en(sym_en), .sending(sending),
        .head(head), .datacmd(datacmd), .ctg(ctg),
        .reg_valid(reg_valid), .reg_id(reg_id), .reg_size(reg_size),
        .data_valid(data_valid), .data_id(data_id), .data_count(data_count),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts each cycle a pulse is seen, and checks exclusivity.
    always @(negedge clk) begin
        if (reg_valid === 1'b1) n_rv++;
        if (data_valid === 1'b1) n_dv++;
        if (err === 1'b1) n_err++;
        if (rst_n) begin
            checks++;
            assert ((32'(reg_valid) + 32'(data_valid) + 32'(err)) <= 1) else begin
                errors++;
                $error("FAIL onehot: observed rv=%b dv=%b err=%b expected at most one", reg_valid, data_valid, err);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input bit en);
        int g;
        if (en) begin
            g = $urandom_range(0, 49);
            repeat (g) begin
                @(negedge clk);
                sending = 1'($urandom); head = 1'($urandom);
                datacmd = 1'($urandom); ctg = 2'($urandom);
            end
        end
    endtask

    task automatic sym(input logic s, input logic h, input logic d, input logic [1:0] c);
        @(negedge clk);
        sending = s; head = h; datacmd = d; ctg = c; sym_en = 1'b1;
        @(negedge clk);
        sym_en = 1'b0;
    endtask

    task automatic beacon(input logic [2:0] id, input logic [15:0] size, input bit gaps, input logic [1:0] body_ctg);
        sym(1, 0, 0, 2'b01); gap(gaps);
        for (int i = 2; i >= 0; i--) begin sym(1, id[i], 0, body_ctg); gap(gaps); end
        for (int i = 15; i >= 0; i--) begin sym(1, size[i], 0, body_ctg); gap(gaps); end
    endtask

    task automatic burst_hdr(input logic [2:0] id);
        sym(1, 1, 0, 2'b10);
        for (int i = 2; i >= 0; i--) sym(1, id[i], 0, 2'b10);
    endtask

    task automatic burst(input logic [2:0] id, input int n);
        burst_hdr(id);
        repeat (n) sym(1, 0, 1, 2'b10);
        sym(0, 0, 0, 2'b10);
    endtask

    task automatic snap;
        s_rv = n_rv; s_dv = n_dv; s_err = n_err;
    endtask

    task automatic deltas(input string tag, input int rv, input int dv, input int er);
        idle(3);
        chk({tag, "_rv"}, n_rv - s_rv, rv);
        chk({tag, "_dv"}, n_dv - s_dv, dv);
        chk({tag, "_err"}, n_err - s_err, er);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_rv", reg_valid, 0); chk("rst_id", reg_id, 0); chk("rst_size", reg_size, 0);
        chk("rst_dv", data_valid, 0); chk("rst_did", data_id, 0); chk("rst_cnt", data_count, 0);
        chk("rst_err", err, 0); chk("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        // Beacon frame: id 5, size 10
        snap;
        beacon(3'd5, 16'd10, 0, 2'b01);
        chk("bcn_pulse", reg_valid, 1);
        chk("bcn_busy", busy, 0);
        deltas("bcn", 1, 0, 0);
        chk("bcn_id", reg_id, 5); chk("bcn_size", reg_size, 10);

        // Scheme burst: id 3, 7 data symbols
        snap;
        burst_hdr(3'd3);
        chk("brst_busy", busy, 1);
        repeat (7) sym(1, 0, 1, 2'b10);
        sym(0, 0, 0, 2'b10);
        chk("brst_pulse", data_valid, 1);
        deltas("brst", 0, 1, 0);
        chk("brst_id", data_id, 3); chk("brst_cnt", data_count, 7);
        chk("brst_regkeep", reg_id, 5);

        // Beacon truncated after 8 symbols
        snap;
        sym(1, 0, 0, 2'b01);
        sym(1, 0, 0, 2'b01); sym(1, 1, 0, 2'b01); sym(1, 0, 0, 2'b01);
        repeat (4) sym(1, 1, 0, 2'b01);
        chk("trunc_noerr_yet", n_err - s_err, 0);
        sym(0, 0, 0, 2'b01);
        chk("trunc_pulse", err, 1);
        deltas("trunc", 0, 0, 1);
        chk("trunc_id", reg_id, 5); chk("trunc_size", reg_size, 10);

        // Reset during DATA after 4 data symbols
        snap;
        burst_hdr(3'd4);
        repeat (4) sym(1, 0, 1, 2'b10);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("mrst_id", reg_id, 0); chk("mrst_size", reg_size, 0);
        chk("mrst_did", data_id, 0); chk("mrst_cnt", data_count, 0);
        chk("mrst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(5);
        chk("mrst_nopulse", (n_rv - s_rv) + (n_dv - s_dv) + (n_err - s_err), 0);
        // First symbol after release is treated as IDLE: a data symbol there is an error
        snap;
        sym(1, 0, 1, 2'b10);
        deltas("post_rst_idle", 0, 0, 1);
        snap;
        burst(3'd6, 2);
        deltas("post_rst", 0, 1, 0);
        chk("post_rst_id", data_id, 6); chk("post_rst_cnt", data_count, 2);

        // Beacon with random sym_en gaps and line noise while sym_en=0
        snap;
        beacon(3'd5, 16'd10, 1, 2'b01);
        sending = 1'b0;
        deltas("gap", 1, 0, 0);
        chk("gap_id", reg_id, 5); chk("gap_size", reg_size, 10);

        // datacmd=0 mid-data: error, no data_valid, data_* retained
        snap;
        burst_hdr(3'd1);
        repeat (3) sym(1, 0, 1, 2'b10);
        sym(1, 0, 0, 2'b10);
        deltas("mid", 0, 0, 1);
        chk("mid_id", data_id, 6); chk("mid_cnt", data_count, 2);
        chk("mid_busy", busy, 0);

        // IDLE: wrong phase with sending=1 errors; sending=0 does nothing
        snap;
        sym(1, 0, 0, 2'b10);
        sym(1, 1, 0, 2'b01);
        sym(1, 0, 0, 2'b11);
        deltas("idle_bad", 0, 0, 3);
        snap;
        sym(0, 0, 0, 2'b01);
        sym(0, 1, 0, 2'b10);
        deltas("idle_quiet", 0, 0, 0);
        chk("idle_quiet_busy", busy, 0);

        // ctg change away from beacon mid-frame is ignored; then abutting beacon
        snap;
        beacon(3'd2, 16'hA5C3, 0, 2'b00);
        chk("ctg_id", reg_id, 2); chk("ctg_size", reg_size, 16'hA5C3);
        beacon(3'd7, 16'h0001, 0, 2'b11);
        deltas("abut", 2, 0, 0);
        chk("abut_id", reg_id, 7); chk("abut_size", reg_size, 1);

        // Burst counter saturates at MAX_COUNT (20)
        snap;
        burst(3'd0, 23);
        deltas("sat", 0, 1, 0);
        chk("sat_id", data_id, 0); chk("sat_cnt", data_count, 20);
        snap;
        burst(3'd7, 20);
        deltas("sat_edge", 0, 1, 0);
        chk("sat_edge_cnt", data_count, 20);

        // Header symbol with datacmd=1 in REG_ID aborts
        snap;
        sym(1, 0, 0, 2'b01);
        sym(1, 1, 1, 2'b01);
        deltas("regid_dc", 0, 0, 1);
        chk("regid_dc_id", reg_id, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
